// File: rtl/dcache_store_req_queue.sv
// Per-thread request FIFOs between ROB commit and the dcache pipeline.
// Buffered requests are issued round-robin across threads, one per cycle, into registered outputs.
package dcache_store_req_queue_pkg;
  typedef struct packed {
    logic        is_store;
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] data;
  } dcache_request_t;
endpackage

module dcache_store_req_queue
  import dcache_store_req_queue_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int THR_W       = 2,
  parameter int DEPTH       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_to_dcache_valid,
  input  dcache_request_t        req_to_dcache_info,
  input  logic [THR_W-1:0]       req_to_dcache_thread_id,
  output logic [NUM_THREADS-1:0] cache_ready,
  output logic                   cache_stage_free_next_cycle,
  output logic [THR_W-1:0]       cache_thread_next_cycle,
  input  logic                   cache_pipe_stall,
  output logic                   dcache_req_valid,
  output dcache_request_t        dcache_req_info,
  output logic [THR_W-1:0]       dcache_req_thread_id,
  output logic                   protocol_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  dcache_request_t mem_q [NUM_THREADS][DEPTH];

  logic [NUM_THREADS-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_THREADS-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_THREADS-1:0][CNT_W-1:0] count_q, count_d;
  logic [THR_W-1:0]                  rr_q, rr_d;
  logic                              valid_q, valid_d;
  dcache_request_t                   info_q, info_d;
  logic [THR_W-1:0]                  tid_q, tid_d;
  logic                              err_q, err_d;

  logic             grant_found;
  logic [THR_W-1:0] grant;
  logic             pop;
  logic             push_ok;
  logic             push_full;

  // Rotating priority: first non-empty thread at or after the RR pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant       = rr_q;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!grant_found && count_q[rr_q + THR_W'(i)] != '0) begin
        grant_found = 1'b1;
        grant       = rr_q + THR_W'(i);
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      cache_ready[t] = count_q[t] < FULL;
    end
  end

  assign push_ok   = req_to_dcache_valid &&  cache_ready[req_to_dcache_thread_id];
  assign push_full = req_to_dcache_valid && !cache_ready[req_to_dcache_thread_id];
  assign pop       = !cache_pipe_stall && grant_found;

  assign cache_stage_free_next_cycle = !grant_found && !cache_pipe_stall;
  assign cache_thread_next_cycle     = grant;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    valid_d  = valid_q;
    info_d   = info_q;
    tid_d    = tid_q;
    err_d    = err_q | push_full;

    for (int t = 0; t < NUM_THREADS; t++) begin
      logic push_t;
      logic pop_t;
      push_t      = push_ok && (req_to_dcache_thread_id == THR_W'(t));
      pop_t       = pop && (grant == THR_W'(t));
      wr_ptr_d[t] = wr_ptr_q[t] + PTR_W'(push_t);
      rd_ptr_d[t] = rd_ptr_q[t] + PTR_W'(pop_t);
      count_d[t]  = count_q[t] + CNT_W'(push_t) - CNT_W'(pop_t);
    end

    // A stalled pipe freezes the output registers, including valid.
    if (!cache_pipe_stall) begin
      valid_d = grant_found;
      if (grant_found) begin
        info_d = mem_q[grant][rd_ptr_q[grant]];
        tid_d  = grant;
        rr_d   = grant + THR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      valid_q  <= 1'b0;
      info_q   <= '0;
      tid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      info_q   <= info_d;
      tid_q    <= tid_d;
      err_q    <= err_d;
    end
  end

  // NOTE: payload storage has no reset; zeroed counts already mark every slot as empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[req_to_dcache_thread_id][wr_ptr_q[req_to_dcache_thread_id]] <= req_to_dcache_info;
    end
  end

  assign dcache_req_valid     = valid_q;
  assign dcache_req_info      = info_q;
  assign dcache_req_thread_id = tid_q;
  assign protocol_error       = err_q;

endmodule

// File: tb/tb_dcache_store_req_queue.sv
// Directed bench for dcache_store_req_queue: inputs driven and outputs sampled on the falling edge.
module tb_dcache_store_req_queue;
  import dcache_store_req_queue_pkg::*;

  logic            clock;
  logic            reset;
  logic            req_to_dcache_valid;
  dcache_request_t req_to_dcache_info;
  logic [1:0]      req_to_dcache_thread_id;
  logic [3:0]      cache_ready;
  logic            cache_stage_free_next_cycle;
  logic [1:0]      cache_thread_next_cycle;
  logic            cache_pipe_stall;
  logic            dcache_req_valid;
  dcache_request_t dcache_req_info;
  logic [1:0]      dcache_req_thread_id;
  logic            protocol_error;

  int total = 0;
  int bad   = 0;

  dcache_store_req_queue #(.NUM_THREADS(4), .THR_W(2), .DEPTH(2)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .req_to_dcache_valid         (req_to_dcache_valid),
    .req_to_dcache_info          (req_to_dcache_info),
    .req_to_dcache_thread_id     (req_to_dcache_thread_id),
    .cache_ready                 (cache_ready),
    .cache_stage_free_next_cycle (cache_stage_free_next_cycle),
    .cache_thread_next_cycle     (cache_thread_next_cycle),
    .cache_pipe_stall            (cache_pipe_stall),
    .dcache_req_valid            (dcache_req_valid),
    .dcache_req_info             (dcache_req_info),
    .dcache_req_thread_id        (dcache_req_thread_id),
    .protocol_error              (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic dcache_request_t mk(input logic [31:0] a);
    dcache_request_t r;
    r.is_store = a[0];
    r.byte_en  = a[7:4];
    r.addr     = a;
    r.data     = ~a;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic [1:0] t, input dcache_request_t info);
    req_to_dcache_valid     = 1'b1;
    req_to_dcache_thread_id = t;
    req_to_dcache_info      = info;
  endtask

  task automatic idle();
    req_to_dcache_valid     = 1'b0;
    req_to_dcache_thread_id = 2'd0;
    req_to_dcache_info      = '0;
  endtask

  task automatic do_reset();
    idle();
    cache_pipe_stall = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    cache_pipe_stall = 1'b0;
    idle();

    // Reset state and single-request latency
    do_reset();
    check("rst_valid", dcache_req_valid, 1'b0);
    check("rst_info", dcache_req_info, '0);
    check("rst_tid", dcache_req_thread_id, 2'd0);
    check("rst_err", protocol_error, 1'b0);
    check("rst_ready", cache_ready, 4'b1111);
    check("rst_free", cache_stage_free_next_cycle, 1'b1);
    check("rst_next", cache_thread_next_cycle, 2'd0);
    push(2'd2, mk(32'hA000_00A0));
    tick();
    idle();
    check("lat_valid_e1", dcache_req_valid, 1'b0);
    check("lat_ready_e1", cache_ready, 4'b1111);
    check("lat_next_e1", cache_thread_next_cycle, 2'd2);
    check("lat_free_e1", cache_stage_free_next_cycle, 1'b0);
    tick();
    check("lat_valid_e2", dcache_req_valid, 1'b1);
    check("lat_tid_e2", dcache_req_thread_id, 2'd2);
    check("lat_info_e2", dcache_req_info, mk(32'hA000_00A0));
    check("lat_ready_e2", cache_ready, 4'b1111);
    check("lat_free_e2", cache_stage_free_next_cycle, 1'b1);
    check("lat_next_e2", cache_thread_next_cycle, 2'd3);

    // Fill thread 1 while stalled, then overflow it
    do_reset();
    cache_pipe_stall = 1'b1;
    push(2'd1, mk(32'hB000_00B1));
    tick();
    push(2'd1, mk(32'hC000_00C1));
    tick();
    check("full_ready", cache_ready, 4'b1101);
    check("full_err0", protocol_error, 1'b0);
    check("full_free", cache_stage_free_next_cycle, 1'b0);
    push(2'd1, mk(32'hD000_00D1));
    tick();
    idle();
    check("ovf_err", protocol_error, 1'b1);
    check("ovf_ready", cache_ready, 4'b1101);
    check("ovf_valid", dcache_req_valid, 1'b0);
    cache_pipe_stall = 1'b0;
    tick();
    check("ovf_pop1_valid", dcache_req_valid, 1'b1);
    check("ovf_pop1_info", dcache_req_info, mk(32'hB000_00B1));
    check("ovf_pop1_tid", dcache_req_thread_id, 2'd1);
    check("ovf_pop1_ready", cache_ready, 4'b1111);
    tick();
    check("ovf_pop2_info", dcache_req_info, mk(32'hC000_00C1));
    check("ovf_err_sticky", protocol_error, 1'b1);
    tick();
    check("ovf_drain_valid", dcache_req_valid, 1'b0);

    // Round robin across threads 0, 1, 3
    do_reset();
    cache_pipe_stall = 1'b1;
    push(2'd0, mk(32'h1000_0010));
    tick();
    push(2'd1, mk(32'h1100_0011));
    tick();
    push(2'd3, mk(32'h1300_0013));
    tick();
    idle();
    cache_pipe_stall = 1'b0;
    check("rr_next0", cache_thread_next_cycle, 2'd0);
    tick();
    check("rr_tid0", dcache_req_thread_id, 2'd0);
    check("rr_info0", dcache_req_info, mk(32'h1000_0010));
    check("rr_next1", cache_thread_next_cycle, 2'd1);
    tick();
    check("rr_tid1", dcache_req_thread_id, 2'd1);
    check("rr_info1", dcache_req_info, mk(32'h1100_0011));
    check("rr_next3", cache_thread_next_cycle, 2'd3);
    tick();
    check("rr_tid3", dcache_req_thread_id, 2'd3);
    check("rr_info3", dcache_req_info, mk(32'h1300_0013));
    check("rr_next_wrap", cache_thread_next_cycle, 2'd0);
    check("rr_valid3", dcache_req_valid, 1'b1);
    tick();
    check("rr_done_valid", dcache_req_valid, 1'b0);

    // Outputs and counts hold for three stalled cycles
    do_reset();
    push(2'd2, mk(32'h2000_0020));
    tick();
    push(2'd2, mk(32'h2100_0021));
    tick();
    check("hold_first_info", dcache_req_info, mk(32'h2000_0020));
    push(2'd2, mk(32'h2200_0022));
    cache_pipe_stall = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold_valid_%0d", k), dcache_req_valid, 1'b1);
      check($sformatf("hold_info_%0d", k), dcache_req_info, mk(32'h2000_0020));
      check($sformatf("hold_tid_%0d", k), dcache_req_thread_id, 2'd2);
      check($sformatf("hold_ready_%0d", k), cache_ready[2], 1'b0);
      if (k < 2) tick();
    end
    cache_pipe_stall = 1'b0;
    tick();
    check("hold_rel_info1", dcache_req_info, mk(32'h2100_0021));
    check("hold_rel_ready", cache_ready[2], 1'b1);
    tick();
    check("hold_rel_info2", dcache_req_info, mk(32'h2200_0022));
    tick();
    check("hold_rel_valid", dcache_req_valid, 1'b0);

    // Thread 0 streaming: push and pop every cycle
    do_reset();
    for (int j = 1; j <= 9; j++) begin
      if (j <= 8) push(2'd0, mk(32'h3000_0000 + 32'(j - 1)));
      else idle();
      tick();
      check($sformatf("strm_ready_%0d", j), cache_ready[0], 1'b1);
      check($sformatf("strm_err_%0d", j), protocol_error, 1'b0);
      if (j >= 2) begin
        check($sformatf("strm_valid_%0d", j), dcache_req_valid, 1'b1);
        check($sformatf("strm_info_%0d", j), dcache_req_info, mk(32'h3000_0000 + 32'(j - 2)));
      end
    end
    idle();
    tick();
    check("strm_end_valid", dcache_req_valid, 1'b0);

    // Reset mid-operation drops buffered requests
    do_reset();
    cache_pipe_stall = 1'b1;
    for (int t = 0; t < 4; t++) begin
      push(2'(t), mk(32'h4000_0000 + 32'(t)));
      tick();
    end
    idle();
    cache_pipe_stall = 1'b0;
    tick();
    check("mid_valid_pre", dcache_req_valid, 1'b1);
    check("mid_tid_pre", dcache_req_thread_id, 2'd0);
    cache_pipe_stall = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_valid_rst", dcache_req_valid, 1'b0);
    check("mid_info_rst", dcache_req_info, '0);
    check("mid_ready_rst", cache_ready, 4'b1111);
    #1;
    reset = 1'b1;
    cache_pipe_stall = 1'b0;
    #1;
    check("mid_free_rel", cache_stage_free_next_cycle, 1'b1);
    check("mid_next_rel", cache_thread_next_cycle, 2'd0);
    tick();
    check("mid_valid_after", dcache_req_valid, 1'b0);
    check("mid_free_after", cache_stage_free_next_cycle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
